// File: rtl/dense_frame_ctrl.sv
// Frame sequencer around dense_top: packs a serial feature stream into wide beats,
// waits for the class scores, and reduces them to a class index with a signed argmax.
module dense_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUMI_ONCE  = 36,
  parameter int NUM_BEATS  = 3,
  parameter int NUM_CLASS  = 7,
  parameter int TIMEOUT    = 1023
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATA_WIDTH*NUMI_ONCE-1:0] dense_data_o,
  output logic                            dense_valid_o,
  input  logic [DATA_WIDTH*NUM_CLASS-1:0] dense_data_i,
  input  logic                            dense_valid_i,
  output logic [2:0]                      class_o,
  output logic [DATA_WIDTH-1:0]           score_o,
  output logic                            result_valid_o,
  output logic                            err_o
);

  localparam int VAL_W  = (NUMI_ONCE > 1) ? $clog2(NUMI_ONCE) : 1;
  localparam int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int SCAN_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  localparam logic [VAL_W-1:0]  VAL_LAST  = VAL_W'(NUMI_ONCE - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NUM_BEATS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_CLASS - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_WAIT   = 2'd1,
    S_ARGMAX = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                            state;
  logic [VAL_W-1:0]                  val_cnt;
  logic [BEAT_W-1:0]                 beat_cnt;
  logic [SCAN_W-1:0]                 scan_cnt;
  logic [WD_W-1:0]                   wd_cnt;
  logic [DATA_WIDTH*NUMI_ONCE-1:0]   pack;
  logic [DATA_WIDTH*NUMI_ONCE-1:0]   pack_nxt;
  logic signed [DATA_WIDTH-1:0]      scores [NUM_CLASS];
  logic signed [DATA_WIDTH-1:0]      best;
  logic signed [DATA_WIDTH-1:0]      score_cur;
  logic [2:0]                        idx;
  logic                              accept;
  logic                              win;

  assign accept = in_valid & in_ready;

  // Packing register with the current value already placed, so the final slot
  // can be forwarded to dense_data_o on the same edge it is accepted.
  always_comb begin
    pack_nxt = pack;
    pack_nxt[int'(val_cnt)*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  // Strictly greater keeps the lower index on ties.
  always_comb begin
    score_cur = scores[scan_cnt];
    win       = (score_cur > best);
  end

  // Frame sequencer with registered outputs; pulse outputs default low each cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= S_FILL;
      val_cnt        <= '0;
      beat_cnt       <= '0;
      scan_cnt       <= '0;
      wd_cnt         <= '0;
      pack           <= '0;
      best           <= '0;
      idx            <= 3'd0;
      in_ready       <= 1'b0;
      dense_data_o   <= '0;
      dense_valid_o  <= 1'b0;
      class_o        <= 3'd0;
      score_o        <= '0;
      result_valid_o <= 1'b0;
      err_o          <= 1'b0;
      for (int i = 0; i < NUM_CLASS; i++) begin
        scores[i] <= '0;
      end
    end else begin
      dense_valid_o  <= 1'b0;
      result_valid_o <= 1'b0;
      err_o          <= 1'b0;
      case (state)
        S_FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            pack <= pack_nxt;
            if (val_cnt == VAL_LAST) begin
              val_cnt       <= '0;
              dense_data_o  <= pack_nxt;
              dense_valid_o <= 1'b1;
              if (beat_cnt == BEAT_LAST) begin
                beat_cnt <= '0;
                wd_cnt   <= '0;
                in_ready <= 1'b0;
                state    <= S_WAIT;
              end else begin
                beat_cnt <= beat_cnt + 1'b1;
              end
            end else begin
              val_cnt <= val_cnt + 1'b1;
            end
          end
          if (dense_valid_i) begin
            err_o <= 1'b1;
          end
        end
        S_WAIT: begin
          // A result arriving on the timeout edge takes priority over the abort.
          if (dense_valid_i) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
              scores[i] <= dense_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
            best     <= dense_data_i[DATA_WIDTH-1:0];
            idx      <= 3'd0;
            scan_cnt <= SCAN_W'(1);
            wd_cnt   <= '0;
            state    <= S_ARGMAX;
          end else if (wd_cnt == WD_LAST) begin
            err_o    <= 1'b1;
            wd_cnt   <= '0;
            val_cnt  <= '0;
            beat_cnt <= '0;
            scan_cnt <= '0;
            in_ready <= 1'b1;
            state    <= S_FILL;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_ARGMAX: begin
          if (win) begin
            best <= score_cur;
            idx  <= 3'(scan_cnt);
          end
          if (scan_cnt == SCAN_LAST) begin
            class_o        <= win ? 3'(scan_cnt) : idx;
            score_o        <= win ? score_cur : best;
            result_valid_o <= 1'b1;
            state          <= S_DONE;
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
          if (dense_valid_i) begin
            err_o <= 1'b1;
          end
        end
        S_DONE: begin
          scan_cnt <= '0;
          in_ready <= 1'b1;
          state    <= S_FILL;
          if (dense_valid_i) begin
            err_o <= 1'b1;
          end
        end
        default: begin
          val_cnt  <= '0;
          beat_cnt <= '0;
          scan_cnt <= '0;
          wd_cnt   <= '0;
          in_ready <= 1'b0;
          state    <= S_FILL;
        end
      endcase
    end
  end

endmodule
